// File: rtl/systolic_array_feeder_ws_seq_pkg.sv
// Shared definitions for the weight-stationary feeder and the array control FSM.
package systolic_array_feeder_ws_seq_pkg;

  // Feeder sequencing states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WEIGHTS = 2'd1,
    ST_DATA    = 2'd2,
    ST_DRAIN   = 2'd3
  } feeder_state_e;

  // Defaults shared with the array control FSM
  localparam int unsigned DATA_WIDTH_DEF       = 8;
  localparam int unsigned WEIGHTS_CYCLE_DEF    = 8;
  localparam int unsigned DATAPATH_LATENCY_DEF = 17;
  localparam int unsigned MAX_DATA_BEATS_DEF   = 1024;

endpackage

// File: rtl/systolic_array_feeder_out_reg.sv
// Registered shared-bus output stage; idle cycles drive an all-zero dummy beat.
module systolic_array_feeder_out_reg #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  accept,
  input  logic [DATA_WIDTH-1:0] beat_data,
  input  logic                  beat_last,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last
);

  // One-cycle latency from acceptance to the bus, zero-filled when nothing is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
    end else begin
      o_valid <= accept;
      o_data  <= accept ? beat_data : '0;
      o_last  <= accept & beat_last;
    end
  end

endmodule

// File: rtl/systolic_array_feeder_ws_seq.sv
// Weight-stationary feeder: muxes weight then activation streams onto the shared
// array bus for one tile per i_start, then waits out the array latency.
module systolic_array_feeder_ws_seq
  import systolic_array_feeder_ws_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int unsigned WEIGHTS_CYCLE    = WEIGHTS_CYCLE_DEF,
  parameter int unsigned DATAPATH_LATENCY = DATAPATH_LATENCY_DEF,
  parameter int unsigned MAX_DATA_BEATS   = MAX_DATA_BEATS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_cmd,
  input  logic                  w_valid,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_ready,
  input  logic                  a_valid,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  a_last,
  output logic                  a_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int unsigned CNT_W_W = $clog2(WEIGHTS_CYCLE) + 1;
  localparam int unsigned CNT_A_W = $clog2(MAX_DATA_BEATS) + 1;
  localparam int unsigned CNT_D_W = $clog2(DATAPATH_LATENCY) + 1;

  feeder_state_e        state;
  logic [CNT_W_W-1:0]   cnt_w;
  logic [CNT_A_W-1:0]   cnt_a;
  logic [CNT_D_W-1:0]   cnt_d;

  logic                  w_acc;
  logic                  a_acc;
  logic                  ovf;
  logic                  w_done;
  logic                  d_done;
  logic                  accept;
  logic [DATA_WIDTH-1:0] beat_data;
  logic                  beat_last;

  // Phase gating: only the stream matching the control FSM phase can be accepted
  assign w_ready   = (state == ST_WEIGHTS) & i_cmd;
  assign a_ready   = (state == ST_DATA) & ~i_cmd;
  assign w_acc     = w_valid & w_ready;
  assign a_acc     = a_valid & a_ready;
  assign w_done    = w_acc & (cnt_w == CNT_W_W'(WEIGHTS_CYCLE - 1));
  assign ovf       = a_acc & ~a_last & (cnt_a == CNT_A_W'(MAX_DATA_BEATS - 1));
  assign d_done    = (state == ST_DRAIN) & (cnt_d == CNT_D_W'(DATAPATH_LATENCY - 1));
  assign accept    = w_acc | a_acc;
  assign beat_data = w_acc ? w_data : a_data;
  assign beat_last = a_acc & (a_last | ovf);

  assign o_busy = (state != ST_IDLE);
  assign o_done = d_done;

  // Tile sequencer: state, beat counters and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt_w <= '0;
      cnt_a <= '0;
      cnt_d <= '0;
      o_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state <= ST_WEIGHTS;
            cnt_w <= '0;
            cnt_a <= '0;
            cnt_d <= '0;
          end
        end
        ST_WEIGHTS: begin
          if (w_done) begin
            state <= ST_DATA;
            cnt_w <= '0;
          end else if (w_acc) begin
            cnt_w <= cnt_w + CNT_W_W'(1);
          end
        end
        ST_DATA: begin
          if (a_acc) begin
            cnt_a <= cnt_a + CNT_A_W'(1);
            if (a_last | ovf) begin
              state <= ST_DRAIN;
              cnt_d <= '0;
            end
            if (ovf) begin
              o_err <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (d_done) begin
            state <= ST_IDLE;
            cnt_d <= '0;
          end else begin
            cnt_d <= cnt_d + CNT_D_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  systolic_array_feeder_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .accept   (accept),
    .beat_data(beat_data),
    .beat_last(beat_last),
    .o_valid  (o_valid),
    .o_data   (o_data),
    .o_last   (o_last)
  );

endmodule

// File: tb/tb_systolic_array_feeder_ws_seq.sv
// Bench for the weight-stationary feeder: directed scenarios plus randomized tiles,
// every cycle compared against a tile-level reference model.
module tb_systolic_array_feeder_ws_seq;

  localparam int unsigned DW   = 8;
  localparam int unsigned WC   = 8;
  localparam int unsigned LAT  = 17;
  localparam int unsigned MAXB = 4;

  logic          clk;
  logic          rst;
  logic          i_start;
  logic          i_cmd;
  logic          w_valid;
  logic [DW-1:0] w_data;
  logic          w_ready;
  logic          a_valid;
  logic [DW-1:0] a_data;
  logic          a_last;
  logic          a_ready;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          o_last;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  systolic_array_feeder_ws_seq #(
    .DATA_WIDTH      (DW),
    .WEIGHTS_CYCLE   (WC),
    .DATAPATH_LATENCY(LAT),
    .MAX_DATA_BEATS  (MAXB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_start(i_start),
    .i_cmd  (i_cmd),
    .w_valid(w_valid),
    .w_data (w_data),
    .w_ready(w_ready),
    .a_valid(a_valid),
    .a_data (a_data),
    .a_last (a_last),
    .a_ready(a_ready),
    .o_valid(o_valid),
    .o_data (o_data),
    .o_last (o_last),
    .o_busy (o_busy),
    .o_done (o_done),
    .o_err  (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 loading weights, 2 streaming activations, 3 draining
  int            m_phase      = 0;
  int            m_w_left     = 0;
  int            m_a_cnt      = 0;
  int            m_drain_left = 0;
  logic          m_valid      = 1'b0;
  logic          m_last       = 1'b0;
  logic          m_err        = 1'b0;
  logic [DW-1:0] m_data       = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_w_left <= 0; m_a_cnt <= 0; m_drain_left <= 0;
      m_valid <= 1'b0; m_last <= 1'b0; m_err <= 1'b0; m_data <= '0;
    end else begin
      m_valid <= 1'b0; m_last <= 1'b0; m_data <= '0;
      case (m_phase)
        0: if (i_start) begin m_phase <= 1; m_w_left <= WC; end
        1: if (i_cmd && w_valid) begin
             m_valid <= 1'b1; m_data <= w_data; m_w_left <= m_w_left - 1;
             if (m_w_left == 1) begin m_phase <= 2; m_a_cnt <= 0; end
           end
        2: if (!i_cmd && a_valid) begin
             m_valid <= 1'b1; m_data <= a_data; m_a_cnt <= m_a_cnt + 1;
             if (a_last || (m_a_cnt + 1 == MAXB)) begin
               m_last <= 1'b1; m_phase <= 3; m_drain_left <= LAT;
               if (!a_last) m_err <= 1'b1;
             end
           end
        3: begin
             m_drain_left <= m_drain_left - 1;
             if (m_drain_left == 1) m_phase <= 0;
           end
        default: m_phase <= 0;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (o_valid !== m_valid) $display("FAIL cyc_o_valid t=%0t: got %b expected %b", $time, o_valid, m_valid);
      else n_pass++;
      n_checks++;
      if (o_data !== m_data) $display("FAIL cyc_o_data t=%0t: got %h expected %h", $time, o_data, m_data);
      else n_pass++;
      n_checks++;
      if (o_last !== m_last) $display("FAIL cyc_o_last t=%0t: got %b expected %b", $time, o_last, m_last);
      else n_pass++;
      n_checks++;
      if (o_busy !== (m_phase != 0)) $display("FAIL cyc_o_busy t=%0t: got %b expected %b", $time, o_busy, (m_phase != 0));
      else n_pass++;
      n_checks++;
      if (o_done !== (m_phase == 3 && m_drain_left == 1))
        $display("FAIL cyc_o_done t=%0t: got %b expected %b", $time, o_done, (m_phase == 3 && m_drain_left == 1));
      else n_pass++;
      n_checks++;
      if (o_err !== m_err) $display("FAIL cyc_o_err t=%0t: got %b expected %b", $time, o_err, m_err);
      else n_pass++;
      n_checks++;
      if (w_ready !== (m_phase == 1 && i_cmd))
        $display("FAIL cyc_w_ready t=%0t: got %b expected %b", $time, w_ready, (m_phase == 1 && i_cmd));
      else n_pass++;
      n_checks++;
      if (a_ready !== (m_phase == 2 && !i_cmd))
        $display("FAIL cyc_a_ready t=%0t: got %b expected %b", $time, a_ready, (m_phase == 2 && !i_cmd));
      else n_pass++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile(input logic [DW-1:0] first_w);
    i_start = 1'b1; i_cmd = 1'b1; w_valid = 1'b1; w_data = first_w;
    @(negedge clk);
    n_checks++;
    if (w_ready !== 1'b0) $display("FAIL start_collision_w_ready: got %b expected 0", w_ready);
    else n_pass++;
    step();
    i_start = 1'b0;
  endtask

  task automatic feed_weights(input logic [DW-1:0] wts[8], input int idle_pct);
    int i = 0;
    int guard = 0;
    bit vld;
    i_cmd = 1'b1;
    while (i < 8 && guard < 200) begin
      vld = ($urandom_range(99) >= idle_pct);
      w_valid = vld; w_data = wts[i];
      @(negedge clk);
      if (vld && w_ready) i++;
      step();
      guard++;
    end
    w_valid = 1'b0; w_data = '0;
    if (i < 8) begin
      n_checks++;
      $display("FAIL weight_feed_timeout: accepted %0d expected 8", i);
    end
  endtask

  task automatic feed_acts(input logic [DW-1:0] acts[$], input int last_idx, input int stall_pct, output int n_acc);
    int i = 0;
    int guard = 0;
    n_acc = 0;
    while (i < acts.size() && guard < 100) begin
      i_cmd = ($urandom_range(99) < stall_pct);
      a_valid = 1'b1; a_data = acts[i]; a_last = (i == last_idx);
      @(negedge clk);
      if (a_ready) begin i++; n_acc++; end
      step();
      guard++;
    end
    a_valid = 1'b0; a_data = '0; a_last = 1'b0; i_cmd = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (k <= 100) begin
      @(negedge clk);
      if (o_done) break;
      step();
      k++;
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b1; w_valid = 1'b1; w_data = 8'hA5; i_cmd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({o_valid, o_last, o_busy, o_done, o_err, w_ready, a_ready} !== 7'b0)
      $display("FAIL reset_flags: got %b expected 0000000", {o_valid, o_last, o_busy, o_done, o_err, w_ready, a_ready});
    else n_pass++;
    n_checks++;
    if (o_data !== 8'h00) $display("FAIL reset_o_data: got %h expected 00", o_data);
    else n_pass++;
    i_start = 1'b0; w_valid = 1'b0; w_data = '0;
    rst = 1'b0;
    step();
    n_checks++;
    if (o_busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", o_busy);
    else n_pass++;
  endtask

  task automatic test_nominal();
    logic [DW-1:0] wts[8];
    logic [DW-1:0] acts[$];
    int n, k;
    for (int i = 0; i < 8; i++) wts[i] = DW'(i + 1);
    acts = '{8'h10, 8'h11, 8'h12, 8'h13};
    start_tile(wts[0]);
    feed_weights(wts, 0);
    feed_acts(acts, 3, 0, n);
    n_checks++;
    if (n !== 4) $display("FAIL nominal_act_count: got %0d expected 4", n);
    else n_pass++;
    n_checks++;
    if ({o_valid, o_last, o_data} !== {1'b1, 1'b1, 8'h13})
      $display("FAIL nominal_last_beat: got v=%b l=%b d=%h expected v=1 l=1 d=13", o_valid, o_last, o_data);
    else n_pass++;
    wait_done(k);
    n_checks++;
    if (k !== 16) $display("FAIL nominal_drain_len: got done after %0d cycles expected 16", k);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0) $display("FAIL nominal_back_idle: got busy=%b expected 0", o_busy);
    else n_pass++;
    step();
  endtask

  task automatic test_phase_gating();
    logic [DW-1:0] wts[8];
    logic [DW-1:0] acts[$];
    int n, k;
    for (int i = 0; i < 8; i++) wts[i] = DW'($urandom);
    start_tile(wts[0]);
    feed_weights(wts, 0);
    i_cmd = 1'b1; a_valid = 1'b1; a_data = 8'h5A; a_last = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (a_ready !== 1'b0 || (c > 0 && o_valid !== 1'b0))
        $display("FAIL gating_hold c=%0d: got a_ready=%b o_valid=%b expected 0/0", c, a_ready, o_valid);
      else n_pass++;
      step();
    end
    i_cmd = 1'b0;
    step();
    n_checks++;
    if ({o_valid, o_data} !== {1'b1, 8'h5A})
      $display("FAIL gating_first_act: got v=%b d=%h expected v=1 d=5a", o_valid, o_data);
    else n_pass++;
    acts = '{8'h6B, 8'h7C};
    feed_acts(acts, 1, 0, n);
    wait_done(k);
    n_checks++;
    if (k !== 16) $display("FAIL gating_drain_len: got %0d expected 16", k);
    else n_pass++;
  endtask

  task automatic test_weight_bubbles_single();
    logic [DW-1:0] acts[$];
    int nv = 0;
    int n, k;
    start_tile(8'h21);
    i_cmd = 1'b1;
    for (int c = 0; c < 16; c++) begin
      w_valid = (c % 2 == 0);
      w_data  = DW'(8'h21 + c / 2);
      @(negedge clk);
      if (o_valid) nv++;
      step();
    end
    w_valid = 1'b0; w_data = '0;
    @(negedge clk);
    if (o_valid) nv++;
    step();
    n_checks++;
    if (nv !== 8) $display("FAIL bubbles_weight_beats: got %0d expected 8", nv);
    else n_pass++;
    acts = '{8'h77};
    feed_acts(acts, 0, 0, n);
    n_checks++;
    if ({n[3:0], o_last, o_data} !== {4'd1, 1'b1, 8'h77})
      $display("FAIL single_beat: got n=%0d l=%b d=%h expected n=1 l=1 d=77", n, o_last, o_data);
    else n_pass++;
    wait_done(k);
    n_checks++;
    if (k !== 16) $display("FAIL single_drain_len: got %0d expected 16", k);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [DW-1:0] wts[8];
    logic [DW-1:0] acts[$];
    int n, k;
    for (int i = 0; i < 8; i++) wts[i] = DW'($urandom);
    acts = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    start_tile(wts[0]);
    feed_weights(wts, 0);
    feed_acts(acts, -1, 0, n);
    n_checks++;
    if (n !== 4) $display("FAIL overflow_accepted: got %0d expected 4", n);
    else n_pass++;
    n_checks++;
    if ({o_last, o_err, o_data} !== {1'b1, 1'b1, 8'hC4})
      $display("FAIL overflow_forced_last: got l=%b e=%b d=%h expected l=1 e=1 d=c4", o_last, o_err, o_data);
    else n_pass++;
    a_valid = 1'b1; a_last = 1'b0;
    for (int c = 0; c < 2; c++) begin
      a_data = DW'(8'hC5 + c);
      @(negedge clk);
      n_checks++;
      if (a_ready !== 1'b0) $display("FAIL overflow_extra_beat c=%0d: got a_ready=%b expected 0", c, a_ready);
      else n_pass++;
      step();
    end
    a_valid = 1'b0; a_data = '0;
    wait_done(k);
    n_checks++;
    if (k !== 14) $display("FAIL overflow_drain_len: got %0d expected 14", k);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (o_err !== 1'b1) $display("FAIL overflow_err_sticky: got %b expected 1", o_err);
    else n_pass++;
    step();
  endtask

  task automatic test_reset_mid_data();
    logic [DW-1:0] wts[8];
    logic [DW-1:0] acts[$];
    int n;
    for (int i = 0; i < 8; i++) wts[i] = DW'($urandom);
    acts = '{8'hD1, 8'hD2};
    start_tile(wts[0]);
    feed_weights(wts, 0);
    feed_acts(acts, -1, 0, n);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({o_valid, o_last, o_busy, o_done, o_err, w_ready, a_ready, o_data} !== 15'b0)
      $display("FAIL midreset_outputs: got v=%b l=%b b=%b dn=%b e=%b wr=%b ar=%b d=%h expected all 0",
               o_valid, o_last, o_busy, o_done, o_err, w_ready, a_ready, o_data);
    else n_pass++;
    step();
    rst = 1'b0;
    step();
    test_nominal();
  endtask

  task automatic test_random(input int ntiles);
    logic [DW-1:0] wts[8];
    logic [DW-1:0] acts[$];
    int nact, n, k;
    for (int t = 0; t < ntiles; t++) begin
      for (int i = 0; i < 8; i++) wts[i] = DW'($urandom);
      nact = int'($urandom_range(MAXB, 1));
      acts.delete();
      for (int i = 0; i < nact; i++) acts.push_back(DW'($urandom));
      if ($urandom_range(1)) begin
        a_valid = 1'b1; a_data = acts[0]; a_last = 1'b0;
      end
      start_tile(wts[0]);
      feed_weights(wts, 30);
      feed_acts(acts, nact - 1, 25, n);
      n_checks++;
      if (n !== nact) $display("FAIL random_act_count t=%0d: got %0d expected %0d", t, n, nact);
      else n_pass++;
      if (t % 3 == 0) begin
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        wait_done(k);
        n_checks++;
        if (k !== 15) $display("FAIL random_drain_start_ignored t=%0d: got %0d expected 15", t, k);
        else n_pass++;
      end else begin
        wait_done(k);
        n_checks++;
        if (k !== 16) $display("FAIL random_drain_len t=%0d: got %0d expected 16", t, k);
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_cmd = 1'b0;
    w_valid = 1'b0; w_data = '0;
    a_valid = 1'b0; a_data = '0; a_last = 1'b0;
    chk_en = 1'b1;
    test_reset();
    test_nominal();
    test_phase_gating();
    test_weight_bubbles_single();
    test_overflow();
    test_reset_mid_data();
    test_random(20);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
